// File: rtl/bpu_ras_pkg.sv
// Shared branch-predictor types: resolved branch kinds and RAS sizing defaults.
package bpu_ras_pkg;

    typedef enum logic [1:0] {
        _ABSOLUTE    = 2'd0,
        _PC_RELATIVE = 2'd1,
        _CALL        = 2'd2,
        _RETURN      = 2'd3
    } br_type_t;

    localparam int RAS_DEPTH = 8;
    localparam int RAS_AW    = 30;

endpackage

// File: rtl/bpu_ras_stack.sv
// Circular return-address stack with saturating occupancy, exposing both its
// current state and its next state so a sibling stack can be reloaded from it.
module ras_stack
    import bpu_ras_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH,
    parameter int AW    = RAS_AW,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic [AW-1:0]             push_data,
    input  logic                      load,
    input  logic [DEPTH-1:0][AW-1:0]  load_mem,
    input  logic [PW-1:0]             load_ptr,
    input  logic [CW-1:0]             load_cnt,
    output logic [DEPTH-1:0][AW-1:0]  mem,
    output logic [PW-1:0]             ptr,
    output logic [CW-1:0]             cnt,
    output logic [DEPTH-1:0][AW-1:0]  mem_nxt,
    output logic [PW-1:0]             ptr_nxt,
    output logic [CW-1:0]             cnt_nxt
);

    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [DEPTH-1:0][AW-1:0] mem_r;
    logic [PW-1:0]            ptr_r;
    logic [CW-1:0]            cnt_r;

    // Next-state: load wins, then replace, push, pop; underflow pops are dropped.
    always_comb begin
        mem_nxt = mem_r;
        ptr_nxt = ptr_r;
        cnt_nxt = cnt_r;
        if (load) begin
            mem_nxt = load_mem;
            ptr_nxt = load_ptr;
            cnt_nxt = load_cnt;
        end else if (push && pop && (cnt_r != {CW{1'b0}})) begin
            mem_nxt[ptr_r - PTR_ONE] = push_data;
        end else if (push) begin
            mem_nxt[ptr_r] = push_data;
            ptr_nxt        = ptr_r + PTR_ONE;
            cnt_nxt        = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
        end else if (pop && (cnt_r != {CW{1'b0}})) begin
            ptr_nxt = ptr_r - PTR_ONE;
            cnt_nxt = cnt_r - CNT_ONE;
        end else begin
            cnt_nxt = cnt_r;
        end
    end

    // State registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_r <= '{default: '0};
            ptr_r <= {PW{1'b0}};
            cnt_r <= {CW{1'b0}};
        end else begin
            mem_r <= mem_nxt;
            ptr_r <= ptr_nxt;
            cnt_r <= cnt_nxt;
        end
    end

    assign mem = mem_r;
    assign ptr = ptr_r;
    assign cnt = cnt_r;

endmodule

// File: rtl/bpu_ras.sv
// Return address stack: speculative copy driven by fetch prediction, committed
// copy driven by resolved branches; a flush reloads speculative from committed.
module bpu_ras
    import bpu_ras_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH,
    parameter int AW    = RAS_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pred_push_i,
    input  logic [AW-1:0] pred_push_addr_i,
    input  logic          pred_pop_i,
    output logic [AW-1:0] pred_top_o,
    output logic          pred_valid_o,
    input  logic          upd_valid_i,
    input  logic [1:0]    upd_br_type_i,
    input  logic [AW-1:0] upd_pc_i,
    input  logic          upd_flush_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);

    logic                     com_push_s;
    logic                     com_pop_s;
    logic [DEPTH-1:0][AW-1:0] com_mem_s, com_mem_nxt_s;
    logic [PW-1:0]            com_ptr_s, com_ptr_nxt_s;
    logic [CW-1:0]            com_cnt_s, com_cnt_nxt_s;
    logic [DEPTH-1:0][AW-1:0] spec_mem_s, spec_mem_nxt_s;
    logic [PW-1:0]            spec_ptr_s, spec_ptr_nxt_s;
    logic [CW-1:0]            spec_cnt_s, spec_cnt_nxt_s;

    // Decode the resolved branch type into committed-stack operations.
    always_comb begin
        com_push_s = 1'b0;
        com_pop_s  = 1'b0;
        case (br_type_t'(upd_br_type_i))
            _CALL:   com_push_s = upd_valid_i;
            _RETURN: com_pop_s  = upd_valid_i;
            default: begin
                com_push_s = 1'b0;
                com_pop_s  = 1'b0;
            end
        endcase
    end

    ras_stack #(.DEPTH(DEPTH), .AW(AW)) u_commit (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (com_push_s),
        .pop       (com_pop_s),
        .push_data (upd_pc_i + ADDR_ONE),
        .load      (1'b0),
        .load_mem  ('{default: '0}),
        .load_ptr  ({PW{1'b0}}),
        .load_cnt  ({CW{1'b0}}),
        .mem       (com_mem_s),
        .ptr       (com_ptr_s),
        .cnt       (com_cnt_s),
        .mem_nxt   (com_mem_nxt_s),
        .ptr_nxt   (com_ptr_nxt_s),
        .cnt_nxt   (com_cnt_nxt_s)
    );

    // The flushing branch is itself committed, so reload from committed next-state.
    ras_stack #(.DEPTH(DEPTH), .AW(AW)) u_spec (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pred_push_i),
        .pop       (pred_pop_i),
        .push_data (pred_push_addr_i),
        .load      (upd_flush_i),
        .load_mem  (com_mem_nxt_s),
        .load_ptr  (com_ptr_nxt_s),
        .load_cnt  (com_cnt_nxt_s),
        .mem       (spec_mem_s),
        .ptr       (spec_ptr_s),
        .cnt       (spec_cnt_s),
        .mem_nxt   (spec_mem_nxt_s),
        .ptr_nxt   (spec_ptr_nxt_s),
        .cnt_nxt   (spec_cnt_nxt_s)
    );

    // Top-of-stack view, driven only from speculative registers.
    always_comb begin
        if (spec_cnt_s != {CW{1'b0}}) begin
            pred_top_o   = spec_mem_s[spec_ptr_s - PTR_ONE];
            pred_valid_o = 1'b1;
        end else begin
            pred_top_o   = {AW{1'b0}};
            pred_valid_o = 1'b0;
        end
    end

endmodule

// File: doc/bpu_ras.md
Name: bpu_ras

Overview:
- Return address stack for the branch predictor.
- Upstream it serves the fetch-side predictor: on a predicted CALL it pushes the link address, and on a predicted RETURN it pops and supplies the target.
- Downstream it consumes the resolved-branch feedback stream (branch type, pc, flush) produced by the branch feedback stage.
- It keeps two copies: a speculative stack driven by prediction and a committed stack driven by resolution. A flush restores speculative from committed.

Parameters:
- DEPTH, 8, number of entries per stack (power of two, at least 2).
- AW, 30, address width (pc[31:2] word address).

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- pred_push_i  input  1  fetch predicted a CALL this cycle
- pred_push_addr_i  input  AW  link word address (call pc[31:2]+1) to push
- pred_pop_i  input  1  fetch predicted a RETURN this cycle
- pred_top_o  output  AW  speculative top-of-stack; 0 when empty
- pred_valid_o  output  1  speculative stack non-empty
- upd_valid_i  input  1  one resolved branch this cycle (feedback bht_update qualified by ~stall)
- upd_br_type_i  input  2  resolved br_type_t (_CALL/_RETURN/_ABSOLUTE/_PC_RELATIVE)
- upd_pc_i  input  AW  resolved branch pc[31:2]
- upd_flush_i  input  1  mispredict or CSR flush from feedback stage

Interface decision (fixed): one clock `clk`; reset `rst_n` is synchronous and active-low.

Behaviour:
- Stack structure
  - Each stack is a circular buffer holding DEPTH entries, a top pointer `ptr` (log2 DEPTH bits) and an occupancy count `cnt` (0..DEPTH, saturating).
  - Top entry is mem[ptr-1] (mod DEPTH).
- Push
  - mem[ptr] <= data; ptr <= ptr+1 (wraps).
  - cnt <= min(cnt+1, DEPTH).
  - Overflow silently overwrites the oldest entry.
- Pop
  - If cnt>0: ptr <= ptr-1 (wraps), cnt <= cnt-1.
  - If cnt==0: no change (underflow ignored).
- Push and pop in the same cycle (replace)
  - If cnt>0: mem[ptr-1] <= data; ptr and cnt unchanged.
  - If cnt==0: behaves as push.
- Committed stack, when upd_valid_i is high
  - _CALL pushes upd_pc_i+1 (AW-bit modular add).
  - _RETURN pops.
  - Other types: no effect.
- Speculative stack
  - Operated by pred_push_i/pred_pop_i with pred_push_addr_i.
- Flush (upd_flush_i=1)
  - Speculative mem, ptr and cnt load the committed stack's next-state, i.e. including the same-cycle upd_valid_i operation, since the flushing branch is itself committed.
  - Same-cycle pred_push_i/pred_pop_i are discarded.
  - upd_flush_i without upd_valid_i (CSR flush) copies the current committed state.
- Outputs
  - pred_top_o = mem_spec[ptr_spec-1] when cnt_spec>0, else 0.
  - pred_valid_o = (cnt_spec!=0).
  - Both are combinational from registers only: no input-to-output combinational path.
- Latency: a push, pop or flush in cycle N is visible on pred_top_o/pred_valid_o in cycle N+1.
- Reset (rst_n=0 at a clk edge)
  - Both ptrs and cnts <= 0; all mem entries <= 0.
  - pred_top_o=0, pred_valid_o=0 from the following cycle.
  - Reset overrides all same-cycle push, pop and flush inputs.
  - Reset mid-sequence discards all state.
- No handshake/backpressure: every input is consumed in the cycle it is asserted.

Decomposition:
- The shared package (bpu.svh) holds:
  - br_type_t and the _CALL/_RETURN/_ABSOLUTE/_PC_RELATIVE constants (already used by the feedback stage);
  - the RAS DEPTH default constant.
- One natural sub-module, `ras_stack`:
  - parameters DEPTH, AW;
  - inputs push, pop, push_data, load, load_mem/load_ptr/load_cnt;
  - outputs mem, ptr, cnt, next-state mem/ptr/cnt.
- bpu_ras instantiates it twice (spec and commit) plus the flush-copy wiring and output muxing.

Test Plan:
- Basic push/pop: after reset, pred_push_i with addr 0x100 then 0x200 → pred_top_o=0x200, valid=1; pop → 0x100; pop → top=0, valid=0; a further pop leaves state unchanged.
- Overflow wrap (DEPTH=8): push 0x1..0x9 → cnt saturates at 8; pop 8 times yields 0x9 down to 0x2; a 9th pop gives valid=0.
- Replace: stack holds [0x10,0x20]; push 0x30 and pop in the same cycle → top=0x30; one pop → top=0x10.
- Flush restore:
  - commit upd_valid_i _CALL pc=0x40 (committed top 0x41);
  - speculatively push 0x50, 0x60, then pop;
  - assert upd_flush_i with no upd_valid_i → next cycle pred_top_o=0x41, valid=1.
- Flush with simultaneous commit: committed holds [0x41]; upd_valid_i _RETURN, upd_flush_i and pred_push_i 0x99 all in one cycle → spec empty, valid=0; 0x99 is not present.
- Reset mid-operation: with 5 entries in both stacks, drop rst_n for one cycle while pred_push_i=1 → pred_valid_o=0 and pred_top_o=0; the next push of 0x7 gives top=0x7, cnt=1.
